obs_channel_scheduler: RTL

- Round-robin scheduler that shares one 2-bit serial observation channel among NREQ requesters.
- Each requester asks for a 16-bit window of the 64-bit monitored data word. The scheduler grants one requester, captures the window in a single cycle and streams it out as 2-bit symbols under a valid/ready handshake.
- Sits between the monitored datapath bus and the evaluation harness's serial sink. It replaces ad-hoc per-instance serialisers.

---
 rtl/obs_channel_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/obs_channel_scheduler.sv
// Round-robin scheduler that shares one SYM-bit serial observation channel among NREQ requesters.
// Define OBS_PARITY_EN to append one parity symbol to each transfer.
module obs_channel_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 64,
    parameter int unsigned WIN     = 16,
    parameter int unsigned SYM     = 2,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_all,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       win_sel,
    input  logic [DW-1:0]           data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [SYM-1:0]          ser_data,
    output logic                    ser_valid,
    input  logic                    ser_ready,
    output logic                    xfer_done,
    output logic [$clog2(NREQ)-1:0] xfer_id
);
    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned NDATA = WIN / SYM;
    localparam int unsigned CW    = $clog2(NDATA + 1);
    localparam int unsigned GW    = 4;
    localparam int unsigned NWIN  = (DW / WIN > 4) ? 4 : DW / WIN;
`ifdef OBS_PARITY_EN
    localparam int unsigned NSYM  = NDATA + 1;
`else
    localparam int unsigned NSYM  = NDATA;
`endif
    localparam int unsigned SRW   = NSYM * SYM;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_GAP} state_e;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            ser_valid_q;
    logic            xfer_done_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  ptr_q;
    logic [SRW-1:0]  sr_q;
    logic [CW-1:0]   cnt_q;
    logic [GW-1:0]   gap_q;

    logic            arb_found_c;
    logic [IDW-1:0]  arb_idx_c;
    int unsigned     arb_dist_c;
    int unsigned     arb_best_c;
    logic [1:0]      sel_c;
    logic [WIN-1:0]  win_c;
    logic [SRW-1:0]  load_c;

    // Nearest set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        arb_dist_c  = 0;
        arb_best_c  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            arb_dist_c = (i >= 32'(ptr_q)) ? i - 32'(ptr_q) : i + NREQ - 32'(ptr_q);
            if (req[i] && (!arb_found_c || arb_dist_c < arb_best_c)) begin
                arb_found_c = 1'b1;
                arb_best_c  = arb_dist_c;
                arb_idx_c   = IDW'(i);
            end
        end
    end

    // Window picked by the granted requester's selector, plus optional parity symbol on top.
    always_comb begin
        sel_c = '0;
        win_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (id_q == IDW'(i)) sel_c = win_sel[2*i +: 2];
        end
        for (int unsigned w = 0; w < NWIN; w++) begin
            if (sel_c == 2'(w)) win_c = data[w*WIN +: WIN];
        end
`ifdef OBS_PARITY_EN
        load_c = {SYM'({^win_c[WIN-1:WIN/2], ^win_c[WIN/2-1:0]}), win_c};
`else
        load_c = win_c;
`endif
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            ser_valid_q <= 1'b0;
            xfer_done_q <= 1'b0;
            id_q        <= '0;
            ptr_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
        end else begin
            xfer_done_q <= 1'b0;
            if (xfer_done_q) id_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (arb_found_c) begin
                        gnt_q   <= NREQ'(1) << arb_idx_c;
                        id_q    <= arb_idx_c;
                        busy_q  <= 1'b1;
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    sr_q        <= load_c;
                    cnt_q       <= '0;
                    ser_valid_q <= 1'b1;
                    state_q     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ser_valid_q && ser_ready) begin
                        sr_q  <= sr_q >> SYM;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NSYM - 1)) begin
                            ser_valid_q <= 1'b0;
                            gnt_q       <= '0;
                            busy_q      <= 1'b0;
                            xfer_done_q <= 1'b1;
                            ptr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                            gap_q       <= '0;
                            state_q     <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYC - 1)) state_q <= S_IDLE;
                    else                           gap_q   <= gap_q + GW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign ser_data  = sr_q[SYM-1:0];
    assign ser_valid = ser_valid_q;
    assign xfer_done = xfer_done_q;
    assign xfer_id   = id_q;

endmodule
